// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, debouncer, edge detector and
// hold/auto-repeat FSM for the active-low KEY push buttons. All outputs are
// registered; every key channel is independent and has identical timing.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_KEYS-1:0] repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LONG} hold_st_e;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic          s1_q, s2_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d, rel_q, rel_d, long_q, long_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    hold_st_e      st_q, st_d;
    logic          disagree, tog, rise, fall, rep_pulse;

    // Two-flop synchroniser; reset loads the released level.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q <= 1'b1;
        s2_q <= 1'b1;
      end else begin
        s1_q <= key_n[k];
        s2_q <= s1_q;
      end
    end

    // Debounce: count consecutive samples disagreeing with the accepted level.
    always_comb begin
      disagree = (~s2_q) != lvl_q;
      tog      = disagree && (dcnt_q == DEB_LAST);
      dcnt_d   = (disagree && !tog) ? dcnt_q + 1'b1 : '0;
      lvl_d    = lvl_q ^ tog;
      rise     = tog && !lvl_q;
      fall     = tog && lvl_q;
    end

    // Hold FSM next state: long-hold detection and auto-repeat scheduling.
    always_comb begin
      st_d      = st_q;
      hcnt_d    = hcnt_q;
      long_d    = long_q;
      rep_pulse = 1'b0;
      case (st_q)
        IDLE: begin
          long_d = 1'b0;
          if (rise) begin
            st_d   = DELAY;
            hcnt_d = '0;
          end
        end
        DELAY: begin
          if (hcnt_q == DLY_LAST) begin
            long_d    = 1'b1;
            hcnt_d    = '0;
            rep_pulse = repeat_en[k];
            st_d      = repeat_en[k] ? REPEAT : LONG;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!repeat_en[k]) begin
            st_d   = LONG;
            hcnt_d = '0;
          end else if (hcnt_q == PER_LAST) begin
            rep_pulse = 1'b1;
            hcnt_d    = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        LONG: begin
          if (repeat_en[k]) begin
            st_d   = REPEAT;
            hcnt_d = '0;
          end
        end
        default: st_d = IDLE;
      endcase
      // A release overrides whatever the hold logic wanted this cycle.
      if (fall) begin
        st_d      = IDLE;
        hcnt_d    = '0;
        long_d    = 1'b0;
        rep_pulse = 1'b0;
      end
      press_d = rise | rep_pulse;
      rel_d   = fall;
    end

    // Debounce, FSM and output registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt_q  <= '0;
        lvl_q   <= 1'b0;
        hcnt_q  <= '0;
        st_q    <= IDLE;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        dcnt_q  <= dcnt_d;
        lvl_q   <= lvl_d;
        hcnt_q  <= hcnt_d;
        st_q    <= st_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end
    end

    assign key_level[k]   = lvl_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = rel_q;
    assign key_long[k]    = long_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: table rows, hand-timed hold/repeat/reset
// sequences, then random key activity against a behavioural model.
module tb_key_conditioner;
  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_n, repeat_en;
  logic [N-1:0] key_level, key_press, key_release, key_long;

  key_conditioner #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
                    .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_model = 0;

  // Behavioural model: delay line, run-length debounce, age-since-press hold.
  bit       m_s1[N], m_s2[N], m_rep[N];
  int       m_cnt[N], m_age[N], m_anchor[N];
  logic [N-1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_lng = '0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [N-1:0] l, input logic [N-1:0] p,
                      input logic [N-1:0] r, input logic [N-1:0] g);
    chk({tag, ".level"},   key_level,   l);
    chk({tag, ".press"},   key_press,   p);
    chk({tag, ".release"}, key_release, r);
    chk({tag, ".long"},    key_long,    g);
  endtask

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      bit pressed_sync, rise, fall;
      e_prs[k] = 1'b0;
      e_rel[k] = 1'b0;
      if (rst) begin
        m_s1[k] = 1; m_s2[k] = 1; m_cnt[k] = 0; m_age[k] = 0; m_rep[k] = 0;
        e_lvl[k] = 0; e_lng[k] = 0;
      end else begin
        pressed_sync = !m_s2[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = key_n[k];
        rise = 0; fall = 0;
        if (pressed_sync != e_lvl[k]) begin
          m_cnt[k]++;
          if (m_cnt[k] == DEB) begin
            m_cnt[k] = 0;
            e_lvl[k] = !e_lvl[k];
            rise = e_lvl[k];
            fall = !e_lvl[k];
          end
        end else m_cnt[k] = 0;
        if (rise) begin
          m_age[k] = 0; m_rep[k] = 0; e_lng[k] = 0; e_prs[k] = 1;
        end else if (fall) begin
          m_rep[k] = 0; e_lng[k] = 0; e_rel[k] = 1;
        end else if (e_lvl[k]) begin
          m_age[k]++;
          if (m_age[k] == RD) begin
            e_lng[k] = 1;
            if (repeat_en[k]) begin
              m_rep[k] = 1; m_anchor[k] = RD; e_prs[k] = 1;
            end
          end else if (m_age[k] > RD) begin
            if (!repeat_en[k]) m_rep[k] = 0;
            else if (!m_rep[k]) begin
              m_rep[k] = 1; m_anchor[k] = m_age[k];
            end else if ((m_age[k] - m_anchor[k]) % RP == 0) e_prs[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (chk_model) chk4("model", e_lvl, e_prs, e_rel, e_lng);
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] kn, ren;
    int           n;
    logic [N-1:0] lvl, prs, rel, lng;
  } vec_t;

  function automatic vec_t row(bit r, logic [N-1:0] kn, logic [N-1:0] ren, int n,
                               logic [N-1:0] l, logic [N-1:0] p, logic [N-1:0] rl,
                               logic [N-1:0] g);
    vec_t v;
    v.rst = r; v.kn = kn; v.ren = ren; v.n = n;
    v.lvl = l; v.prs = p; v.rel = rl; v.lng = g;
    return v;
  endfunction

  vec_t tbl[$];
  int   rl[N];

  initial begin
    rst = 1'b1; key_n = '1; repeat_en = '0;

    // Reset behaviour, short glitch, plain press/release on key 1.
    tbl.push_back(row(1, 4'hF, 4'h0, 3,  4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(row(1, 4'h0, 4'h0, 4,  4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(row(0, 4'hF, 4'h0, 10, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(row(0, 4'hE, 4'h0, 3,  4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(row(0, 4'hF, 4'h0, 8,  4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(row(0, 4'hD, 4'h0, 5,  4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(row(0, 4'hD, 4'h0, 1,  4'h2, 4'h2, 4'h0, 4'h0));
    tbl.push_back(row(0, 4'hD, 4'h0, 2,  4'h2, 4'h0, 4'h0, 4'h0));
    tbl.push_back(row(0, 4'hF, 4'h0, 5,  4'h2, 4'h0, 4'h0, 4'h0));
    tbl.push_back(row(0, 4'hF, 4'h0, 1,  4'h0, 4'h0, 4'h2, 4'h0));
    tbl.push_back(row(0, 4'hF, 4'h0, 4,  4'h0, 4'h0, 4'h0, 4'h0));
    foreach (tbl[r]) begin
      rst = tbl[r].rst; key_n = tbl[r].kn; repeat_en = tbl[r].ren;
      for (int c = 0; c < tbl[r].n; c++) begin
        tick();
        chk4($sformatf("row%0d", r), tbl[r].lvl, tbl[r].prs, tbl[r].rel, tbl[r].lng);
      end
    end

    // Key 2 held 30 cycles with repeat: press at L, L+10, then every 3.
    repeat_en = 4'h4; key_n = 4'hB;
    for (int i = 1; i <= 40; i++) begin
      bit p;
      tick();
      p = (i == 6) || (i >= 16 && i <= 34 && (i - 16) % 3 == 0);
      chk4($sformatf("rep2[%0d]", i), (i >= 6 && i <= 35) ? 4'h4 : 4'h0,
           p ? 4'h4 : 4'h0, (i == 36) ? 4'h4 : 4'h0,
           (i >= 16 && i <= 35) ? 4'h4 : 4'h0);
      if (i == 30) key_n = 4'hF;
    end

    // Key 3 held without repeat, repeat enabled at L+20.
    repeat_en = 4'h0; key_n = 4'h7;
    for (int i = 1; i <= 42; i++) begin
      bit p;
      tick();
      p = (i == 6) || (i >= 29 && i <= 38 && (i - 29) % 3 == 0);
      chk4($sformatf("long3[%0d]", i), (i >= 6 && i <= 38) ? 4'h8 : 4'h0,
           p ? 4'h8 : 4'h0, (i == 39) ? 4'h8 : 4'h0,
           (i >= 16 && i <= 38) ? 4'h8 : 4'h0);
      if (i == 25) repeat_en = 4'h8;
      if (i == 33) key_n = 4'hF;
    end

    // Keys 0 and 3 together, reset pulse at L+12 while still held.
    repeat_en = 4'hF; key_n = 4'h6;
    for (int i = 1; i <= 26; i++) begin
      bit lv, p, g;
      tick();
      lv = (i >= 6 && i <= 17) || (i >= 24);
      p  = (i == 6) || (i == 16) || (i == 24);
      g  = (i == 16) || (i == 17);
      chk4($sformatf("rst03[%0d]", i), lv ? 4'h9 : 4'h0, p ? 4'h9 : 4'h0,
           4'h0, g ? 4'h9 : 4'h0);
      if (i == 17) rst = 1'b1;
      if (i == 18) rst = 1'b0;
    end
    key_n = 4'hF; repeat_en = 4'h0;
    repeat (12) tick();

    // Random bouncing keys, repeat toggling and occasional reset.
    chk_model = 1;
    foreach (rl[k]) rl[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (rl[k] == 0) begin
          int t;
          key_n[k] = 1'($urandom_range(0, 1));
          t = $urandom_range(0, 9);
          rl[k] = (t < 3) ? $urandom_range(1, 4) :
                  (t < 6) ? $urandom_range(5, 10) : $urandom_range(12, 40);
        end
        rl[k]--;
        if ($urandom_range(0, 19) == 0) repeat_en[k] = ~repeat_en[k];
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
